// File: rtl/stream_palindrome_checker_pkg.sv
// Shared types and sizing helpers for the stream palindrome checker.
// Imported by the interface, the symbol buffer and the top level.
package palindrome_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CHECK   = 2'd1,
    DONE    = 2'd2
  } pal_state_t;

  localparam int DEF_SYM_WIDTH = 8;
  localparam int DEF_MAX_LEN   = 64;

  // Width able to hold every count from 0 up to and including max_len.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/stream_palindrome_checker_if.sv
// Symbol stream input and result output of the palindrome checker.
// master = symbol source / result consumer side, slave = checker side.
interface stream_palindrome_checker_if #(
  parameter int SYM_WIDTH = 8,
  parameter int LEN_W     = 7
);
  logic                 in_valid;
  logic                 in_ready;
  logic [SYM_WIDTH-1:0] in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_pal;
  logic                 out_overflow;
  logic [LEN_W-1:0]     out_len;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_pal, out_overflow, out_len
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_pal, out_overflow, out_len
  );
endinterface

// File: rtl/stream_palindrome_checker_sym_buf.sv
// Frame storage: MAX_LEN symbols, one synchronous write port and two
// asynchronous read ports used to walk the frame from both ends.
module palin_sym_buf #(
  parameter int SYM_WIDTH = 8,
  parameter int MAX_LEN   = 64,
  parameter int ADDR_W    = $clog2(MAX_LEN)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [SYM_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]    lo_addr,
  input  logic [ADDR_W-1:0]    hi_addr,
  output logic [SYM_WIDTH-1:0] lo_data,
  output logic [SYM_WIDTH-1:0] hi_data
);

  logic [SYM_WIDTH-1:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign lo_data = mem[lo_addr];
  assign hi_data = mem[hi_addr];

endmodule

// File: rtl/stream_palindrome_checker.sv
// Buffers a framed symbol stream, then compares one symbol pair per cycle
// from both ends and reports palindrome / overflow / length.
module stream_palindrome_checker
  import palindrome_pkg::*;
#(
  parameter int SYM_WIDTH = DEF_SYM_WIDTH,
  parameter int MAX_LEN   = DEF_MAX_LEN,
  parameter int LEN_W     = len_width(MAX_LEN)
) (
  input  logic                          clk,
  input  logic                          reset,
  stream_palindrome_checker_if.slave    bus,
  output pal_state_t                    fsm_state
);

  localparam int ADDR_W = $clog2(MAX_LEN);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // in_ready and out_valid are pure functions of state (never of the peer's
  // valid/ready), and result fields hold steady while out_valid && !out_ready.

  pal_state_t state, state_next;

  logic [LEN_W-1:0]     count, len, lo, hi, count_inc;
  logic                 ovf, cnt_full, ovf_now, in_fire, out_fire;
  logic                 pairs_done, mismatch;
  logic                 res_pal, res_ovf;
  logic [LEN_W-1:0]     res_len;
  logic [SYM_WIDTH-1:0] lo_data, hi_data;

  assign bus.in_ready     = (state == COLLECT);
  assign bus.out_valid    = (state == DONE);
  assign bus.out_pal      = res_pal;
  assign bus.out_overflow = res_ovf;
  assign bus.out_len      = res_len;
  assign fsm_state        = state;

  assign in_fire    = bus.in_valid && (state == COLLECT);
  assign out_fire   = bus.out_ready && (state == DONE);
  assign cnt_full   = (count == LEN_W'(MAX_LEN));
  assign count_inc  = cnt_full ? count : count + LEN_W'(1);
  assign ovf_now    = ovf || (in_fire && cnt_full);
  assign pairs_done = (lo >= hi);
  assign mismatch   = (lo_data != hi_data);

  palin_sym_buf #(
    .SYM_WIDTH (SYM_WIDTH),
    .MAX_LEN   (MAX_LEN),
    .ADDR_W    (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .we      (in_fire && !cnt_full),
    .wr_addr (count[ADDR_W-1:0]),
    .wr_data (bus.in_data),
    .lo_addr (lo[ADDR_W-1:0]),
    .hi_addr (hi[ADDR_W-1:0]),
    .lo_data (lo_data),
    .hi_data (hi_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= COLLECT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (in_fire && bus.in_last) state_next = ovf_now ? DONE : CHECK;
      CHECK:   if (pairs_done || mismatch) state_next = DONE;
      DONE:    if (out_fire) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      ovf     <= 1'b0;
      len     <= '0;
      lo      <= '0;
      hi      <= '0;
      res_pal <= 1'b0;
      res_ovf <= 1'b0;
      res_len <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_fire) begin
            count <= count_inc;
            if (cnt_full) ovf <= 1'b1;
            if (bus.in_last) begin
              len <= count_inc;
              lo  <= '0;
              hi  <= count_inc - LEN_W'(1);
              // Overflowed frames skip the walk and report straight away.
              if (ovf_now) begin
                res_pal <= 1'b0;
                res_ovf <= 1'b1;
                res_len <= count_inc;
              end
            end
          end
        end
        CHECK: begin
          if (pairs_done) begin
            res_pal <= 1'b1;
            res_len <= len;
          end else if (mismatch) begin
            res_pal <= 1'b0;
            res_len <= len;
          end else begin
            lo <= lo + LEN_W'(1);
            hi <= hi - LEN_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            count   <= '0;
            ovf     <= 1'b0;
            res_pal <= 1'b0;
            res_ovf <= 1'b0;
            res_len <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_palindrome_checker.sv
// Directed-frame bench for stream_palindrome_checker: a driver feeds frames,
// expected results and output cycles go into queues, a monitor pops and compares.
module tb_stream_palindrome_checker;
  import palindrome_pkg::*;

  localparam int SYM_WIDTH = 8;
  localparam int MAX_LEN   = 64;
  localparam int LEN_W     = len_width(MAX_LEN);
  localparam int RES_W     = LEN_W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  stream_palindrome_checker_if #(.SYM_WIDTH(SYM_WIDTH), .LEN_W(LEN_W)) bus ();
  pal_state_t fsm_state;

  stream_palindrome_checker #(
    .SYM_WIDTH (SYM_WIDTH),
    .MAX_LEN   (MAX_LEN),
    .LEN_W     (LEN_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .fsm_state (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [RES_W-1:0] exp_q[$];
  int               exp_cyc_q[$];
  logic [SYM_WIDTH-1:0] frame_q[$];
  int   rise_cyc   = 0;
  logic prev_valid = 1'b0;
  logic prev_fire  = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [RES_W-1:0] e;
    int ec;
    if (reset) begin
      prev_valid = 1'b0;
      prev_fire  = 1'b0;
    end else begin
      if (prev_fire) check("valid_pulse_drop", int'(bus.out_valid), 0);
      if (bus.out_valid && !prev_valid) rise_cyc = cyc + 1;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got pal=%0d ovf=%0d len=%0d, none expected",
                   bus.out_pal, bus.out_overflow, bus.out_len);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("result_word", int'({bus.out_overflow, bus.out_pal, bus.out_len}), int'(e));
          check("result_cycle", rise_cyc, ec);
        end
      end
      prev_valid = bus.out_valid;
      prev_fire  = bus.out_valid && bus.out_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_str(input string s);
    frame_q.delete();
    for (int i = 0; i < s.len(); i++) frame_q.push_back(s[i]);
  endtask

  task automatic load_fill(input logic [SYM_WIDTH-1:0] sym, input int n);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(sym);
  endtask

  // Sends frame_q; if track, expects {ovf,pal,len} with out_valid at N+lat.
  task automatic send_frame(input bit track, input logic ovf, input logic pal,
                            input int len, input int lat);
    logic rdy;
    bit   accepted;
    int   wait_cnt;
    if (track) exp_q.push_back({ovf, pal, LEN_W'(len)});
    for (int i = 0; i < frame_q.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = frame_q[i];
      bus.in_last  = (i == frame_q.size() - 1);
      accepted = 0;
      wait_cnt = 0;
      while (!accepted) begin
        @(negedge clk);
        rdy = bus.in_ready;
        @(posedge clk); #1;
        if (rdy) accepted = 1;
        else if (++wait_cnt > 300) begin
          check("in_ready_timeout", 0, 1);
          finish_sim();
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (track) exp_cyc_q.push_back(cyc + lat);
  endtask

  task automatic wait_results();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("results_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    do_reset();

    @(negedge clk);
    check("reset_in_ready",  int'(bus.in_ready), 1);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out_pal",   int'(bus.out_pal), 0);
    check("reset_out_ovf",   int'(bus.out_overflow), 0);
    check("reset_out_len",   int'(bus.out_len), 0);
    check("reset_state",     int'(fsm_state), int'(COLLECT));
    @(posedge clk); #1;

    load_str("racecar");  send_frame(1, 1'b0, 1'b1, 7, 5);
    load_str("abcd");     send_frame(1, 1'b0, 1'b0, 4, 2);
    load_fill(8'h5A, 1);  send_frame(1, 1'b0, 1'b1, 1, 2);
    load_fill(8'h00, MAX_LEN + 3); send_frame(1, 1'b1, 1'b0, MAX_LEN, 1);
    load_fill(8'h00, MAX_LEN);     send_frame(1, 1'b0, 1'b1, MAX_LEN, MAX_LEN / 2 + 2);
    load_str("abcdba");   send_frame(1, 1'b0, 1'b0, 6, 4);
    wait_results();

    // Hold the result for 10 cycles with the consumer stalled.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    load_str("abba");     send_frame(1, 1'b0, 1'b1, 4, 4);
    begin
      int n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("stall_valid_seen", int'(bus.out_valid), 1);
    end
    for (int i = 0; i < 10; i++) begin
      check("stall_out_valid", int'(bus.out_valid), 1);
      check("stall_in_ready",  int'(bus.in_ready), 0);
      check("stall_out_pal",   int'(bus.out_pal), 1);
      check("stall_out_ovf",   int'(bus.out_overflow), 0);
      check("stall_out_len",   int'(bus.out_len), 4);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    load_str("xx");       send_frame(1, 1'b0, 1'b1, 2, 3);
    wait_results();

    // Reset while the frame is being walked: no result may appear.
    @(posedge clk); #1;
    load_str("abba");     send_frame(0, 1'b0, 1'b0, 0, 0);
    check("pre_reset_state", int'(fsm_state), int'(CHECK));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_in_ready",  int'(bus.in_ready), 1);
    check("midreset_out_valid", int'(bus.out_valid), 0);
    check("midreset_state",     int'(fsm_state), int'(COLLECT));
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    load_str("level");    send_frame(1, 1'b0, 1'b1, 5, 4);
    wait_results();

    check("exp_cyc_q_empty", exp_cyc_q.size(), 0);
    finish_sim();
  end

  initial begin
    #200000;
    check("global_timeout", 0, 1);
    finish_sim();
  end

endmodule
